mmu_bram_responder: RTL and testbench
=====================================

# mmu_bram_responder

Synthesizable single-port block-RAM memory that acts as the responder for the core MMU's instruction-read, data-read and data-write request channels. It sits below `mmu`, in place of the external memory path, and lets riscv-tests images run without the AXI subsystem. It arbitrates the three channels onto one RAM port and returns read data with its address tag. It throttles the MMU through `MEM_WAIT` when requests collide.

## Interface
Parameters:
- `ADDR_BASE`, 32'h2000_0000: byte address mapped to RAM word 0.
- `DEPTH_LOG2`, 12: RAM depth is 2^DEPTH_LOG2 32-bit words.

Ports:
- `CLK` in 1: the only clock.
- `RST` in 1: reset, synchronous and active-high.
- `INST_RDEN` in 1: instruction read request.
- `INST_RIADDR` in 32: instruction read byte address.
- `INST_ROADDR` out 32: address tag returned with the instruction data.
- `INST_RVALID` out 1: one-cycle pulse; instruction data valid.
- `INST_RDATA` out 32: instruction word.
- `DATA_RDEN` in 1: data read request.
- `DATA_RIADDR` in 32: data read byte address.
- `DATA_ROADDR` out 32: address tag returned with the data.
- `DATA_RVALID` out 1: one-cycle pulse; data valid.
- `DATA_RDATA` out 32: full data word.
- `DATA_WREN` in 1: data write request.
- `DATA_WADDR` in 32: data write byte address.
- `DATA_WSTRB` in 4: byte-lane enables.
- `DATA_WDATA` in 32: write data, lane-aligned.
- `MEM_WAIT` out 1: requests are not accepted while this is high.

## Operation
- **RAM index:** word index = (addr − ADDR_BASE)[DEPTH_LOG2+1:2]. Address bits [1:0] are ignored. Reads always return the full word.
- **In range:** ADDR_BASE ≤ addr < ADDR_BASE + 4·2^DEPTH_LOG2.
  - An out-of-range read completes normally with RDATA = 0.
  - An out-of-range write is dropped.
- **Acceptance:** a request is accepted in any cycle where its enable is high and `MEM_WAIT` = 0. Requests presented while `MEM_WAIT` = 1 are ignored; the MMU re-presents them.
- **Arbitration:** the RAM port performs one access per cycle. Priority is data write > data read > instruction read.
- **Pending slots:** accepted requests that lose arbitration are latched (address tag) in a per-channel pending slot, `pend_d` or `pend_i`. The RAM never holds a pending write, because a write always wins.
- **MEM_WAIT** = `pend_d` | `pend_i`.
- **States:**
  - IDLE (no slot full): serve the highest-priority accepted request; latch the rest → PEND if any latched.
  - PEND: serve `pend_d` first, then `pend_i`, one per cycle. No new acceptance. → IDLE when the last slot is served.
- **Write:** byte lane k is updated iff `DATA_WSTRB[k]`. A write with strobe 0000 is accepted and changes nothing.
- **Ordering:** a write and a read to the same word in the same cycle apply the write first. The read, served a cycle later, returns the new data.
- **RAM contents** are not cleared by `RST`. The bench preloads them through the RAM array.

## Timing
- Read served (RAM accessed) in cycle N → `*_RVALID` = 1 in cycle N+1, for exactly one cycle. `*_ROADDR` echoes the request address unmodified; `*_RDATA` holds the word.
- **Uncontended read latency:** 1 cycle.
- **Write:** the RAM is updated at the end of the acceptance cycle. There is no response.
- **Three requests in cycle N:** write served in N; data read in N+1 (`DATA_RVALID` in N+2); instruction read in N+2 (`INST_RVALID` in N+3). `MEM_WAIT` is high in N+1 and N+2 and low in N+3.
- **Reset values:** `INST_RVALID`, `DATA_RVALID`, `MEM_WAIT` = 0; `INST_ROADDR`, `INST_RDATA`, `DATA_ROADDR`, `DATA_RDATA` = 0; pending slots empty; state IDLE.
- **Reset mid-operation:** `RST` sampled high discards pending slots and in-flight reads. No `RVALID` occurs in the cycle after reset. A write accepted in the reset cycle is discarded.
- Outputs other than `MEM_WAIT` are registered. `MEM_WAIT` is decoded from registered state only.

## Test plan
- **Preload and single read:** preload word 0 = 0x0000_0013, then `INST_RDEN` at 0x2000_0000 in cycle N → `INST_RVALID` in N+1, `INST_ROADDR` = 0x2000_0000, `INST_RDATA` = 0x0000_0013, `MEM_WAIT` stays 0.
- **Byte write:** write 0xAABBCCDD with strobe 0100 to 0x2000_0010 over a stored 0x1122_3344 → a subsequent read of 0x2000_0012 returns 0x11BB_3344.
- **Full collision:** write 0xDEAD_BEEF to 0x2000_0020, data read of 0x2000_0020 and instruction read of 0x2000_0000, all in cycle N → `DATA_RVALID` in N+2 with 0xDEAD_BEEF; `INST_RVALID` in N+3; `MEM_WAIT` = 1 in N+1..N+2 only.
- **Ignored request:** a request presented while `MEM_WAIT` = 1 is not served. When re-presented after `MEM_WAIT` falls, it is served once.
- **Out of range:** a read of 0x1FFF_FFFC → RVALID with RDATA = 0. A write to 0x2000_4000 (DEPTH_LOG2 = 12) leaves word 0 unchanged.
- **Reset during PEND:** assert `RST` in N+1 of the collision case → no `INST_RVALID` or `DATA_RVALID` afterward, `MEM_WAIT` = 0 in N+2, and the RAM still holds 0xDEAD_BEEF at 0x2000_0020.

Source files
------------

// File: rtl/mmu_bram_responder.sv
// Single-port block RAM answering the MMU instruction-read, data-read and data-write channels.
// Colliding requests are parked in per-channel pending slots and MEM_WAIT holds off the MMU.
module mmu_bram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h2000_0000,
  parameter int          DEPTH_LOG2 = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Offset wraps modulo 2^32, so addresses below the base land far out of range.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return off[DEPTH_LOG2+1:2];
  endfunction

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic        pend_d_vld_q, pend_d_vld_d;
  logic        pend_i_vld_q, pend_i_vld_d;
  logic [31:0] pend_d_addr_q, pend_d_addr_d;
  logic [31:0] pend_i_addr_q, pend_i_addr_d;

  logic        mem_wait_s;
  logic        acc_w_s, acc_dr_s, acc_ir_s;
  logic        wr_en_s, rd_d_en_s, rd_i_en_s;
  logic [31:0] rd_addr_s;
  logic [31:0] rd_data_s;

  assign mem_wait_s = pend_d_vld_q | pend_i_vld_q;
  assign MEM_WAIT   = mem_wait_s;
  assign acc_w_s    = DATA_WREN & ~mem_wait_s;
  assign acc_dr_s   = DATA_RDEN & ~mem_wait_s;
  assign acc_ir_s   = INST_RDEN & ~mem_wait_s;

  // Pick the one RAM access of this cycle and park the losers.
  always_comb begin
    state_d       = state_q;
    pend_d_vld_d  = pend_d_vld_q;
    pend_i_vld_d  = pend_i_vld_q;
    pend_d_addr_d = pend_d_addr_q;
    pend_i_addr_d = pend_i_addr_q;
    wr_en_s       = 1'b0;
    rd_d_en_s     = 1'b0;
    rd_i_en_s     = 1'b0;
    rd_addr_s     = DATA_RIADDR;
    case (state_q)
      ST_IDLE: begin
        if (acc_w_s) begin
          wr_en_s       = 1'b1;
          pend_d_vld_d  = acc_dr_s;
          pend_d_addr_d = DATA_RIADDR;
          pend_i_vld_d  = acc_ir_s;
          pend_i_addr_d = INST_RIADDR;
        end else if (acc_dr_s) begin
          rd_d_en_s     = 1'b1;
          rd_addr_s     = DATA_RIADDR;
          pend_i_vld_d  = acc_ir_s;
          pend_i_addr_d = INST_RIADDR;
        end else begin
          rd_i_en_s     = acc_ir_s;
          rd_addr_s     = INST_RIADDR;
        end
      end
      ST_PEND: begin
        if (pend_d_vld_q) begin
          rd_d_en_s    = 1'b1;
          rd_addr_s    = pend_d_addr_q;
          pend_d_vld_d = 1'b0;
        end else begin
          rd_i_en_s    = pend_i_vld_q;
          rd_addr_s    = pend_i_addr_q;
          pend_i_vld_d = 1'b0;
        end
      end
      default: begin
        pend_d_vld_d = 1'b0;
        pend_i_vld_d = 1'b0;
      end
    endcase
    if (pend_d_vld_d || pend_i_vld_d) begin
      state_d = ST_PEND;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Out-of-range reads return zero rather than an aliased word.
  always_comb begin
    if (in_range(rd_addr_s)) begin
      rd_data_s = mem_q[word_idx(rd_addr_s)];
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Byte-lane write; RAM contents survive reset, but a write in the reset cycle is dropped.
  always_ff @(posedge CLK) begin
    if (wr_en_s && !RST && in_range(DATA_WADDR)) begin
      for (int k = 0; k < 4; k++) begin
        if (DATA_WSTRB[k]) begin
          mem_q[word_idx(DATA_WADDR)][8*k +: 8] <= DATA_WDATA[8*k +: 8];
        end
      end
    end
  end

  // Control state, pending slots and registered read responses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      pend_d_vld_q  <= 1'b0;
      pend_i_vld_q  <= 1'b0;
      pend_d_addr_q <= 32'd0;
      pend_i_addr_q <= 32'd0;
      INST_RVALID   <= 1'b0;
      INST_ROADDR   <= 32'd0;
      INST_RDATA    <= 32'd0;
      DATA_RVALID   <= 1'b0;
      DATA_ROADDR   <= 32'd0;
      DATA_RDATA    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pend_d_vld_q  <= pend_d_vld_d;
      pend_i_vld_q  <= pend_i_vld_d;
      pend_d_addr_q <= pend_d_addr_d;
      pend_i_addr_q <= pend_i_addr_d;
      INST_RVALID   <= rd_i_en_s;
      DATA_RVALID   <= rd_d_en_s;
      if (rd_i_en_s) begin
        INST_ROADDR <= rd_addr_s;
        INST_RDATA  <= rd_data_s;
      end
      if (rd_d_en_s) begin
        DATA_ROADDR <= rd_addr_s;
        DATA_RDATA  <= rd_data_s;
      end
    end
  end

endmodule

// File: tb/tb_mmu_bram_responder.sv
// Directed bench for mmu_bram_responder: a cycle-indexed expectation model plus literal spot checks.
module tb_mmu_bram_responder;

  localparam int          MAXC = 256;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INST_RDEN = 1'b0;
  logic [31:0] INST_RIADDR = 32'd0;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        DATA_RDEN = 1'b0;
  logic [31:0] DATA_RIADDR = 32'd0;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN = 1'b0;
  logic [31:0] DATA_WADDR = 32'd0;
  logic [3:0]  DATA_WSTRB = 4'd0;
  logic [31:0] DATA_WDATA = 32'd0;
  logic        MEM_WAIT;

  mmu_bram_responder dut (
    .CLK(CLK), .RST(RST),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
    .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WSTRB(DATA_WSTRB),
    .DATA_WDATA(DATA_WDATA), .MEM_WAIT(MEM_WAIT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] mmem [4096];
  logic        exp_iv [MAXC];
  logic        exp_dv [MAXC];
  logic        exp_wait [MAXC];
  logic [31:0] exp_ia [MAXC];
  logic [31:0] exp_id [MAXC];
  logic [31:0] exp_da [MAXC];
  logic [31:0] exp_dd [MAXC];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic m_in(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0000_4000);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_in(a)) return mmem[m_idx(a)];
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Per-cycle comparison of the DUT against the model's timeline.
  always @(negedge CLK) begin
    if (cyc >= 1 && cyc < MAXC) begin
      check("inst_rvalid", {31'd0, INST_RVALID}, {31'd0, exp_iv[cyc]});
      check("data_rvalid", {31'd0, DATA_RVALID}, {31'd0, exp_dv[cyc]});
      check("mem_wait", {31'd0, MEM_WAIT}, {31'd0, exp_wait[cyc]});
      if (exp_iv[cyc]) begin
        check("inst_roaddr", INST_ROADDR, exp_ia[cyc]);
        check("inst_rdata", INST_RDATA, exp_id[cyc]);
      end
      if (exp_dv[cyc]) begin
        check("data_roaddr", DATA_ROADDR, exp_da[cyc]);
        check("data_rdata", DATA_RDATA, exp_dd[cyc]);
      end
    end
  end

  // One cycle of stimulus; the model schedules the k-th accepted request at cycle+k.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da,
                      input logic w, input logic [31:0] wa, input logic [3:0] ws,
                      input logic [31:0] wd);
    int c;
    int k;
    @(negedge CLK);
    RST = rst;
    INST_RDEN = ir; INST_RIADDR = ia;
    DATA_RDEN = dr; DATA_RIADDR = da;
    DATA_WREN = w; DATA_WADDR = wa; DATA_WSTRB = ws; DATA_WDATA = wd;
    c = cyc;
    k = 0;
    if (rst) begin
      for (int j = c + 1; j < MAXC; j++) begin
        exp_iv[j] = 1'b0; exp_dv[j] = 1'b0; exp_wait[j] = 1'b0;
      end
    end else if (!exp_wait[c]) begin
      if (w) begin
        if (m_in(wa)) begin
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) mmem[m_idx(wa)][8*b +: 8] = wd[8*b +: 8];
          end
        end
        k++;
      end
      if (dr) begin
        exp_dv[c+k+1] = 1'b1; exp_da[c+k+1] = da; exp_dd[c+k+1] = m_read(da);
        k++;
      end
      if (ir) begin
        exp_iv[c+k+1] = 1'b1; exp_ia[c+k+1] = ia; exp_id[c+k+1] = m_read(ia);
        k++;
      end
      for (int j = 1; j < k; j++) exp_wait[c+j] = 1'b1;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask
  task automatic rd_i(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask
  task automatic rd_d(input logic [31:0] a);
    step(1'b0, 1'b0, 32'd0, 1'b1, a, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, a, s, d);
  endtask
  task automatic collide();
    step(1'b0, 1'b1, 32'h2000_0000, 1'b1, 32'h2000_0020, 1'b1, 32'h2000_0020, 4'hF, 32'hDEAD_BEEF);
  endtask

  initial begin
    for (int j = 0; j < MAXC; j++) begin
      exp_iv[j] = 1'b0; exp_dv[j] = 1'b0; exp_wait[j] = 1'b0;
      exp_ia[j] = 32'd0; exp_id[j] = 32'd0; exp_da[j] = 32'd0; exp_dd[j] = 32'd0;
    end
    for (int j = 0; j < 4096; j++) mmem[j] = 32'd0;
    mmem[0] = 32'h0000_0013; dut.mem_q[0] = 32'h0000_0013;
    mmem[1] = 32'h0010_0093; dut.mem_q[1] = 32'h0010_0093;
    mmem[4] = 32'h1122_3344; dut.mem_q[4] = 32'h1122_3344;
    mmem[8] = 32'h0000_0000; dut.mem_q[8] = 32'h0000_0000;

    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    idle();
    check("reset_inst_roaddr", INST_ROADDR, 32'd0);
    check("reset_data_rdata", DATA_RDATA, 32'd0);

    // Preloaded single instruction read
    rd_i(32'h2000_0000);
    idle();
    check("single_rvalid", {31'd0, INST_RVALID}, 32'd1);
    idle();
    check("single_rdata", INST_RDATA, 32'h0000_0013);
    check("single_roaddr", INST_ROADDR, 32'h2000_0000);

    // Byte-lane write then read of an unaligned address in the same word
    wr(32'h2000_0010, 4'b0100, 32'hAABB_CCDD);
    rd_d(32'h2000_0012);
    idle();
    idle();
    check("bytewr_rdata", DATA_RDATA, 32'h11BB_3344);
    check("bytewr_model", mmem[4], 32'h11BB_3344);

    // Strobe 0000 changes nothing
    wr(32'h2000_0010, 4'b0000, 32'hFFFF_FFFF);
    rd_d(32'h2000_0010);
    idle();
    check("strb0_rdata", DATA_RDATA, 32'h11BB_3344);

    // Full collision with an instruction read presented during the wait
    collide();
    rd_i(32'h2000_0004);
    check("coll_wait_n1", {31'd0, MEM_WAIT}, 32'd1);
    rd_i(32'h2000_0004);
    check("coll_wait_n2", {31'd0, MEM_WAIT}, 32'd1);
    check("coll_drdata", DATA_RDATA, 32'hDEAD_BEEF);
    rd_i(32'h2000_0004);
    check("coll_wait_n3", {31'd0, MEM_WAIT}, 32'd0);
    check("coll_irdata", INST_RDATA, 32'h0000_0013);
    idle();
    idle();
    check("represent_rdata", INST_RDATA, 32'h0010_0093);

    // Out-of-range read and write
    rd_d(32'h1FFF_FFFC);
    idle();
    check("oor_rvalid", {31'd0, DATA_RVALID}, 32'd1);
    check("oor_rdata", DATA_RDATA, 32'd0);
    check("oor_roaddr", DATA_ROADDR, 32'h1FFF_FFFC);
    wr(32'h2000_4000, 4'hF, 32'hCAFE_F00D);
    rd_i(32'h2000_0000);
    idle();
    check("oor_wr_word0", INST_RDATA, 32'h0000_0013);

    // Reset while both pending slots are full
    wr(32'h2000_0020, 4'hF, 32'h0000_0000);
    collide();
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
    idle();
    check("rstpend_wait", {31'd0, MEM_WAIT}, 32'd0);
    check("rstpend_dvalid", {31'd0, DATA_RVALID}, 32'd0);
    check("rstpend_droaddr", DATA_ROADDR, 32'd0);
    idle();
    check("rstpend_ivalid", {31'd0, INST_RVALID}, 32'd0);
    check("rstpend_ram", dut.mem_q[8], 32'hDEAD_BEEF);

    // A write in a reset cycle is discarded
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h2000_0020, 4'hF, 32'h1234_5678);
    idle();
    check("rstwr_ram", dut.mem_q[8], 32'hDEAD_BEEF);
    rd_d(32'h2000_0020);
    idle();
    check("rstwr_rdata", DATA_RDATA, 32'hDEAD_BEEF);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
